thor2023_dcache_line_fill: RTL and testbench
============================================

Name: thor2023_dcache_line_fill

Overview:
- Miss-fill engine directly upstream of the data cache.
- On a load miss it fetches one or two consecutive 32-byte half-lines over a read-only burst bus, one for each even/odd bank. It assembles each half-line and presents it to the cache with a one-cycle write strobe and the matching update address.
- It reports completion or bus error to the memory pipeline.

Parameters:
- ADR_WID, 32, address width in bits.
- BUS_WID, 128, bus data width in bits; must divide 256.
- TMO, 255, cycles without ack before a beat is declared timed out; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_req  in  1  start fill; sampled only in IDLE
- miss_adr  in  ADR_WID  missing byte address
- miss_two  in  1  fetch the following half-line as well (access straddles bit 5)
- busy  out  1  engine not in IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on bus error or timeout
- cyc_o  out  1  bus cycle
- stb_o  out  1  beat strobe
- adr_o  out  ADR_WID  beat address, aligned to BUS_WID/8
- dat_i  in  BUS_WID  read data
- ack_i  in  1  beat acknowledge
- err_i  in  1  bus error
- wr_o  out  1  cache half-line write strobe (drives wr_dc2)
- update_adr  out  ADR_WID  half-line address, bits [4:0] = 0
- line_o  out  257  {m, data[255:0]}; m always 0 on fill

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, timeout counter 0.
- Reset asserted mid-fill drops cyc_o/stb_o the same edge; no wr_o, done or err is produced.
- BEATS = 256/BUS_WID; 2 at default.
- States:
  - IDLE: on miss_req, latch base = {miss_adr[ADR_WID-1:5], 5'b0} and latch two = miss_two. Go to REQ. busy=1 from the next cycle.
  - REQ: cyc_o=stb_o=1, adr_o = base + beat*BUS_WID/8.
    - On ack_i (err_i=0): store dat_i into line beat slot (beat 0 = least significant), reset timeout, beat++. After the last beat, go to WR with stb_o dropped; cyc_o is held only if a second half-line follows.
    - On err_i, or timeout reaching TMO: go to ABORT.
    - ack_i and err_i together count as an error.
  - WR: wr_o=1 for exactly one cycle; update_adr=base; line_o valid that cycle.
    - If two=1: base += 32 (wraps modulo 2^ADR_WID), two=0, beat=0, back to REQ.
    - Otherwise go to DONE.
  - DONE: done=1 one cycle, cyc_o=0, then IDLE.
  - ABORT: err=1 one cycle, cyc_o=stb_o=0, then IDLE. A half-line already written stays written; the partial half-line is never written.
- Latency with zero-wait ack:
  - Single fill: req cycle 0; beats on cycles 1..BEATS; wr_o on BEATS+1; done on BEATS+2.
  - Double fill: second-half wr_o lands at 2*BEATS+2; done at 2*BEATS+3.
- miss_req while busy is ignored (not queued).
- miss_req in the same cycle done pulses is ignored; it is accepted the following cycle.
- Timeout counter saturates at TMO and is cleared on each ack.
- line_o and update_adr hold their last values outside WR. The consumer uses them only with wr_o.

Test Plan:
- Single fill: miss_adr=0x0000_1234, miss_two=0, zero-wait ack.
  - adr_o sequence = 0x1220, 0x1230.
  - wr_o once with update_adr=0x1220, line_o = {1'b0, beat1, beat0}.
  - done exactly 4 cycles after miss_req.
- Double fill: miss_adr=0x0000_103C, miss_two=1.
  - wr_o twice, update_adr = 0x1020 then 0x1040.
  - cyc_o stays high between the two halves.
  - done one cycle after the second wr_o.
- Wrap: miss_adr=0xFFFF_FFE8, miss_two=1 -> second update_adr = 0x0000_0000.
- Error: err_i on beat 1 of the second half -> the first half is written, no second wr_o, err pulses once, done never pulses, busy drops.
- Timeout, TMO=4: no ack_i -> err pulses after 4 stalled cycles, no wr_o.
- Reset and stalls:
  - rst asserted while in REQ -> all outputs 0 next cycle.
  - miss_req asserted while busy is ignored; adr_o is unchanged.
  - Random ack_i stalls still produce the same line_o as the zero-wait case.

Source files
------------

// File: rtl/thor2023_dcache_line_fill.sv
// Data-cache miss-fill engine.
// Fetches one or two consecutive 32-byte half-lines over a read-only burst bus,
// assembles each half-line from BUS_WID-wide beats and hands it to the cache
// with a single-cycle write strobe, then reports completion or bus error.
module thor2023_dcache_line_fill #(
    parameter int unsigned ADR_WID = 32,
    parameter int unsigned BUS_WID = 128,
    parameter int unsigned TMO     = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_req,
    input  logic [ADR_WID-1:0] miss_adr,
    input  logic               miss_two,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cyc_o,
    output logic               stb_o,
    output logic [ADR_WID-1:0] adr_o,
    input  logic [BUS_WID-1:0] dat_i,
    input  logic               ack_i,
    input  logic               err_i,
    output logic               wr_o,
    output logic [ADR_WID-1:0] update_adr,
    output logic [256:0]       line_o
);

    localparam int unsigned    BEATS     = 256 / BUS_WID;
    localparam int unsigned    BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned    BSH       = $clog2(BUS_WID / 8);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [7:0]     TMO_LIM   = 8'(TMO);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WR,
        DONE,
        ABORT
    } state_t;

    state_t             state_q;
    logic [ADR_WID-1:0] base_q;
    logic               two_q;
    logic [BCW-1:0]     beat_q;
    logic [7:0]         tmo_q;
    logic [7:0]         tmo_d;
    logic [255:0]       buf_q;
    logic [255:0]       fill_d;

    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               cyc_q;
    logic               stb_q;
    logic               wr_q;
    logic [ADR_WID-1:0] upd_q;
    logic [256:0]       line_q;

    // Half-line buffer with the current beat slot replaced by the bus data,
    // so the last beat can go straight into the output line register.
    for (genvar g = 0; g < BEATS; g++) begin : g_slot
        assign fill_d[g*BUS_WID +: BUS_WID] =
            (beat_q == BCW'(g)) ? dat_i : buf_q[g*BUS_WID +: BUS_WID];
    end

    // Stall counter saturates at the timeout limit.
    assign tmo_d = (tmo_q == TMO_LIM) ? tmo_q : tmo_q + 8'd1;

    // Beat address is derived from the half-line base and the beat index.
    assign adr_o = base_q + (ADR_WID'(beat_q) << BSH);

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign wr_o       = wr_q;
    assign update_adr = upd_q;
    assign line_o     = line_q;

    // Fill FSM with registered bus, cache-write and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            two_q   <= 1'b0;
            beat_q  <= '0;
            tmo_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            wr_q    <= 1'b0;
            upd_q   <= '0;
            line_q  <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_req) begin
                        base_q  <= miss_adr & ~ADR_WID'(31);
                        two_q   <= miss_two;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (err_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ABORT;
                    end else if (ack_i) begin
                        tmo_q <= '0;
                        if (beat_q == LAST_BEAT) begin
                            line_q  <= {1'b0, fill_d};
                            upd_q   <= base_q;
                            wr_q    <= 1'b1;
                            stb_q   <= 1'b0;
                            // Keep the bus cycle open across into the second half-line.
                            cyc_q   <= two_q;
                            state_q <= WR;
                        end else begin
                            buf_q  <= fill_d;
                            beat_q <= beat_q + 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_d;
                        if (tmo_d == TMO_LIM) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ABORT;
                        end
                    end
                end
                WR: begin
                    if (two_q) begin
                        base_q  <= base_q + ADR_WID'(32);
                        two_q   <= 1'b0;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        stb_q   <= 1'b1;
                        state_q <= REQ;
                    end else begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ABORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thor2023_dcache_line_fill.sv
// Scoreboard bench for the data-cache miss-fill engine.
// Stimulus pushes expected beats, half-line writes and done/err pulses into
// queues; a negedge monitor pops and compares whenever the engine shows them.
module tb_thor2023_dcache_line_fill;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_req = 1'b0;
    logic [31:0]   miss_adr = '0;
    logic          miss_two = 1'b0;
    logic          busy, done, err, cyc_o, stb_o, wr_o;
    logic [31:0]   adr_o, update_adr;
    logic [127:0]  dat_i = '0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic [256:0]  line_o;

    thor2023_dcache_line_fill #(
        .ADR_WID(32),
        .BUS_WID(128),
        .TMO(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss_req(miss_req),
        .miss_adr(miss_adr),
        .miss_two(miss_two),
        .busy(busy),
        .done(done),
        .err(err),
        .cyc_o(cyc_o),
        .stb_o(stb_o),
        .adr_o(adr_o),
        .dat_i(dat_i),
        .ack_i(ack_i),
        .err_i(err_i),
        .wr_o(wr_o),
        .update_adr(update_adr),
        .line_o(line_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]  adr;
        logic [256:0] line;
        logic         cyc;
        int           cyc_no;
    } wr_exp_t;

    logic [31:0] adr_exp[$];
    wr_exp_t     wr_exp[$];
    int          done_exp[$];
    int          err_exp[$];

    // Responder controls: 0 zero-wait, 1 random short stalls, 2 never ack.
    int   mode = 0;
    int   err_beat = -1;
    logic err_with_ack = 1'b0;
    int   beat_no = 0;
    int   stall = 0;

    function automatic logic [127:0] mem(input logic [31:0] a);
        return {a ^ 32'hDEAD_0000, ~a, a + 32'h1111_1111, a};
    endfunction

    function automatic logic [256:0] line_of(input logic [31:0] b);
        return {1'b0, mem(b + 32'd16), mem(b)};
    endfunction

    task automatic chk(input string name, input logic [256:0] got, input logic [256:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, expected none (cycle %0d)", name, cyc_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc_cnt < n) step();
    endtask

    task automatic issue(input logic [31:0] a, input logic two);
        miss_req = 1'b1;
        miss_adr = a;
        miss_two = two;
        step();
        miss_req = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] b, input logic c, input int cno);
        wr_exp_t w;
        w.adr    = b;
        w.line   = line_of(b);
        w.cyc    = c;
        w.cyc_no = cno;
        wr_exp.push_back(w);
    endtask

    // b0/b1: hand-computed half-line bases; k: cycle miss_req is sampled.
    task automatic expect_fill(input int k, input logic [31:0] b0, input logic [31:0] b1,
                               input logic two, input logic timed);
        adr_exp.push_back(b0);
        adr_exp.push_back(b0 + 32'd16);
        push_wr(b0, two, timed ? k + 3 : -1);
        if (two) begin
            adr_exp.push_back(b1);
            adr_exp.push_back(b1 + 32'd16);
            push_wr(b1, 1'b0, timed ? k + 6 : -1);
            done_exp.push_back(timed ? k + 7 : -1);
        end else begin
            done_exp.push_back(timed ? k + 4 : -1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) unexpected("idle_timeout");
        repeat (2) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 257'({busy, done, err, cyc_o, stb_o, wr_o}), '0);
        chk({tag, "_adr"}, 257'(adr_o), '0);
        chk({tag, "_upd"}, 257'(update_adr), '0);
        chk({tag, "_line"}, line_o, '0);
    endtask

    // Bus slave: drives ack/err/data shortly after each rising edge.
    initial begin
        forever begin
            step();
            if (ack_i && !err_i) beat_no++;
            if (!busy) beat_no = 0;
            ack_i = 1'b0;
            err_i = 1'b0;
            if (stb_o && !rst) begin
                dat_i = mem(adr_o);
                if (beat_no == err_beat) begin
                    err_i = 1'b1;
                    ack_i = err_with_ack;
                end else if (mode == 0) begin
                    ack_i = 1'b1;
                end else if (mode == 1) begin
                    if (stall >= 2 || $urandom_range(0, 2) == 0) begin
                        ack_i = 1'b1;
                        stall = 0;
                    end else begin
                        stall++;
                    end
                end
            end
        end
    end

    logic [31:0] ea;
    wr_exp_t     we;
    int          ec;

    // Monitor: compare every observed beat, write and status pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb_o && ack_i && !err_i) begin
                if (adr_exp.size() == 0) unexpected("beat");
                else begin
                    ea = adr_exp.pop_front();
                    chk("beat_adr", 257'(adr_o), 257'(ea));
                end
            end
            if (wr_o) begin
                if (wr_exp.size() == 0) unexpected("wr_o");
                else begin
                    we = wr_exp.pop_front();
                    chk("update_adr", 257'(update_adr), 257'(we.adr));
                    chk("line_o", line_o, we.line);
                    chk("cyc_in_wr", 257'(cyc_o), 257'(we.cyc));
                    if (we.cyc_no >= 0) chk("wr_cycle", 257'(cyc_cnt), 257'(we.cyc_no));
                end
            end
            if (done) begin
                if (done_exp.size() == 0) unexpected("done");
                else begin
                    ec = done_exp.pop_front();
                    if (ec >= 0) chk("done_cycle", 257'(cyc_cnt), 257'(ec));
                end
            end
            if (err) begin
                if (err_exp.size() == 0) unexpected("err");
                else begin
                    ec = err_exp.pop_front();
                    if (ec >= 0) chk("err_cycle", 257'(cyc_cnt), 257'(ec));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk_zero("reset");
        step();
        rst = 1'b0;
        repeat (2) step();

        // Single fill; miss_req while busy and during done are ignored
        k = cyc_cnt;
        expect_fill(k, 32'h0000_1220, 32'h0, 1'b0, 1'b1);
        issue(32'h0000_1234, 1'b0);
        issue(32'h5555_0040, 1'b1);
        goto(k + 4);
        miss_req = 1'b1;
        miss_adr = 32'h0000_2008;
        miss_two = 1'b0;
        expect_fill(k + 5, 32'h0000_2000, 32'h0, 1'b0, 1'b1);
        step();
        step();
        miss_req = 1'b0;
        wait_idle();

        // Double fill
        k = cyc_cnt;
        expect_fill(k, 32'h0000_1020, 32'h0000_1040, 1'b1, 1'b1);
        issue(32'h0000_103C, 1'b1);
        wait_idle();

        // Address wrap on the second half-line
        k = cyc_cnt;
        expect_fill(k, 32'hFFFF_FFE0, 32'h0000_0000, 1'b1, 1'b1);
        issue(32'hFFFF_FFE8, 1'b1);
        wait_idle();

        // Bus error on beat 1 of the second half: first half written only
        k = cyc_cnt;
        err_beat = 3;
        err_with_ack = 1'b0;
        adr_exp.push_back(32'h0000_3000);
        adr_exp.push_back(32'h0000_3010);
        adr_exp.push_back(32'h0000_3020);
        push_wr(32'h0000_3000, 1'b1, k + 3);
        err_exp.push_back(k + 6);
        issue(32'h0000_3004, 1'b1);
        goto(k + 7);
        @(negedge clk);
        chk("busy_after_err", 257'(busy), '0);
        step();
        err_beat = -1;
        wait_idle();

        // ack_i together with err_i on the first beat is an error
        k = cyc_cnt;
        err_beat = 0;
        err_with_ack = 1'b1;
        err_exp.push_back(k + 2);
        issue(32'h0000_4000, 1'b0);
        goto(k + 3);
        @(negedge clk);
        chk("busy_after_ackerr", 257'(busy), '0);
        step();
        err_beat = -1;
        err_with_ack = 1'b0;
        wait_idle();

        // Timeout with TMO=4 and no ack
        k = cyc_cnt;
        mode = 2;
        err_exp.push_back(k + 5);
        issue(32'h0000_5000, 1'b0);
        wait_idle();
        mode = 0;

        // Random stalls give the same lines as zero-wait
        mode = 1;
        k = cyc_cnt;
        expect_fill(k, 32'h0000_6000, 32'h0000_6020, 1'b1, 1'b0);
        issue(32'h0000_6010, 1'b1);
        wait_idle();
        k = cyc_cnt;
        expect_fill(k, 32'h0000_1220, 32'h0, 1'b0, 1'b0);
        issue(32'h0000_1234, 1'b0);
        wait_idle();
        mode = 0;

        // Reset while in REQ clears every output on the next cycle
        k = cyc_cnt;
        adr_exp.push_back(32'h0000_7000);
        issue(32'h0000_7000, 1'b0);
        goto(k + 2);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_zero("mid_reset");
        step();
        rst = 1'b0;
        repeat (4) step();

        // Nothing left outstanding
        chk("adr_queue_empty", 257'(adr_exp.size()), '0);
        chk("wr_queue_empty", 257'(wr_exp.size()), '0);
        chk("done_queue_empty", 257'(done_exp.size()), '0);
        chk("err_queue_empty", 257'(err_exp.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
